// File: rtl/mips_multicycle_control.sv
// Main control FSM for a multi-cycle MIPS datapath.
// It sequences FETCH/DECODE/EXEC/MEM/WB, decodes opcode/funct into the
// 5-bit ALU operation code, and drives the datapath strobes.
//
// Memory handshake: a request (mem_read_o / mem_write_o) is held for as long
// as the FSM sits in FETCH or MEM. The cycle in which mem_ready_i is high
// completes the transfer. If ready never arrives, the FSM gives up after
// MEM_TIMEOUT cycles. The request stays asserted during that last cycle,
// together with the bus_error_o pulse, and the FSM then returns to FETCH.
// A ready that arrives on the limit cycle still completes normally.
module mips_multicycle_control #(
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  input  logic                mem_ready_i,
  output logic [ALU_OP_W-1:0] alu_operation_o,
  output logic                alu_src_b_o,
  output logic                pc_write_o,
  output logic                pc_src_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                illegal_o,
  output logic                bus_error_o,
  output logic [2:0]          state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_ORI  = 5'd3;
  localparam logic [4:0] OP_SRL  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_LUI  = 5'd6;
  localparam logic [4:0] OP_ANDI = 5'd7;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_BNE  = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_AND  = 5'd13;
  localparam logic [4:0] OP_JMP  = 5'd14;
  localparam logic [4:0] OP_JAL  = 5'd15;
  localparam logic [4:0] OP_JR   = 5'd16;

  // Instruction classes: these decide the path taken after EXEC.
  localparam logic [2:0] C_ALU = 3'd0;  // register writeback of an ALU result
  localparam logic [2:0] C_LW  = 3'd1;
  localparam logic [2:0] C_SW  = 3'd2;
  localparam logic [2:0] C_PC  = 3'd3;  // beq/bne/j/jr: PC update only
  localparam logic [2:0] C_JAL = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [4:0] alu_op_q, alu_op_d;
  logic [2:0] cls_q, cls_d;
  logic       imm_q, imm_d;
  logic       rtype_q, rtype_d;
  logic [7:0] wait_q, wait_d;

  logic [4:0] dec_op;
  logic [2:0] dec_cls;
  logic       dec_imm;
  logic       dec_legal;
  logic       mem_phase;
  logic       timeout;
  logic [4:0] alu_op_out;

  // Decode the instruction-register fields into an ALU op and an instruction class.
  always_comb begin
    dec_op    = OP_ADD;
    dec_cls   = C_ALU;
    dec_imm   = 1'b0;
    dec_legal = 1'b1;
    if (opcode_i == 6'h00) begin
      case (funct_i)
        6'h20:   dec_op = OP_ADD;
        6'h22:   dec_op = OP_SUB;
        6'h24:   dec_op = OP_AND;
        6'h25:   dec_op = OP_OR;
        6'h27:   dec_op = OP_NOR;
        6'h00:   dec_op = OP_SLL;
        6'h02:   dec_op = OP_SRL;
        6'h08:   begin dec_op = OP_JR; dec_cls = C_PC; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (opcode_i)
        6'h08:   begin dec_op = OP_ADD;  dec_imm = 1'b1; end
        6'h0C:   begin dec_op = OP_ANDI; dec_imm = 1'b1; end
        6'h0D:   begin dec_op = OP_ORI;  dec_imm = 1'b1; end
        6'h0F:   begin dec_op = OP_LUI;  dec_imm = 1'b1; end
        6'h23:   begin dec_op = OP_ADD;  dec_imm = 1'b1; dec_cls = C_LW; end
        6'h2B:   begin dec_op = OP_ADD;  dec_imm = 1'b1; dec_cls = C_SW; end
        6'h04:   begin dec_op = OP_BEQ;  dec_cls = C_PC;  end
        6'h05:   begin dec_op = OP_BNE;  dec_cls = C_PC;  end
        6'h02:   begin dec_op = OP_JMP;  dec_cls = C_PC;  end
        6'h03:   begin dec_op = OP_JAL;  dec_cls = C_JAL; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = mem_phase && !mem_ready_i && (wait_q == WAIT_LAST);

  // Next-state logic and the memory wait counter. The counter clears whenever
  // the FSM leaves a waiting state or times out, so it always starts at 0 on entry.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    alu_op_d = alu_op_q;
    cls_d    = cls_q;
    imm_d    = imm_q;
    rtype_d  = rtype_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (timeout) state_d = S_FETCH;
        else              wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        alu_op_d = dec_op;
        cls_d    = dec_cls;
        imm_d    = dec_imm;
        rtype_d  = (opcode_i == 6'h00);
        state_d  = dec_legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        if (cls_q == C_PC || cls_q == C_JAL)    state_d = S_FETCH;
        else if (cls_q == C_LW || cls_q == C_SW) state_d = S_MEM;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready_i)  state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FETCH;
        else              wait_d  = wait_q + 8'd1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // State, decoded-op and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      alu_op_q <= OP_ADD;
      cls_q    <= C_ALU;
      imm_q    <= 1'b0;
      rtype_q  <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      cls_q    <= cls_d;
      imm_q    <= imm_d;
      rtype_q  <= rtype_d;
      wait_q   <= wait_d;
    end
  end

  // Datapath strobes. Everything is forced low while reset is asserted, so an
  // aborted instruction cannot write anything in the reset cycle.
  always_comb begin
    alu_op_out   = OP_ADD;
    alu_src_b_o  = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'd0;
    mem_to_reg_o = 1'b0;
    illegal_o    = 1'b0;
    bus_error_o  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
          bus_error_o = timeout;
        end
        S_DECODE: illegal_o = !dec_legal;
        S_EXEC: begin
          alu_op_out  = alu_op_q;
          alu_src_b_o = imm_q;
          if (cls_q == C_PC || cls_q == C_JAL) begin
            pc_write_o = 1'b1;
            pc_src_o   = 1'b1;
          end
          if (cls_q == C_JAL) begin
            reg_write_o = 1'b1;
            reg_dst_o   = 2'd2;
          end
        end
        S_MEM: begin
          i_or_d_o    = 1'b1;
          mem_read_o  = (cls_q == C_LW);
          mem_write_o = (cls_q == C_SW);
          bus_error_o = timeout;
        end
        S_WB: begin
          reg_write_o  = 1'b1;
          reg_dst_o    = rtype_q ? 2'd1 : 2'd0;
          mem_to_reg_o = (cls_q == C_LW);
        end
        default: ;
      endcase
    end
  end

  assign alu_operation_o = ALU_OP_W'(alu_op_out);
  assign state_o         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control. For each instruction, a reference model
// expands the opcode/funct and the memory latencies into the cycle-by-cycle
// trace that should appear on the outputs. It also builds the matching
// mem_ready_i schedule. The bench replays that schedule and compares every
// cycle against the model.
module tb_mips_multicycle_control;

  localparam int LIMIT = 255;

  typedef struct packed {
    logic [2:0] state;
    logic [4:0] alu_op;
    logic       alu_src_b;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_error;
  } obs_t;

  localparam int KALU_R = 0, KALU_I = 1, KLW = 2, KSW = 3, KPC = 4, KJAL = 5, KILL = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode_i = '0;
  logic [5:0] funct_i = '0;
  logic       mem_ready_i = 1'b0;
  logic [4:0] alu_operation_o;
  logic       alu_src_b_o, pc_write_o, pc_src_o, ir_write_o, mem_read_o, mem_write_o;
  logic       i_or_d_o, reg_write_o, mem_to_reg_o, illegal_o, bus_error_o;
  logic [1:0] reg_dst_o;
  logic [2:0] state_o;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  obs_t exp_q[$];
  logic rdy_q[$];
  obs_t got;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i),
    .mem_ready_i(mem_ready_i), .alu_operation_o(alu_operation_o),
    .alu_src_b_o(alu_src_b_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .ir_write_o(ir_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .i_or_d_o(i_or_d_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o), .bus_error_o(bus_error_o),
    .state_o(state_o)
  );

  assign got = {state_o, alu_operation_o, alu_src_b_o, pc_write_o, pc_src_o, ir_write_o,
                mem_read_o, mem_write_o, i_or_d_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                illegal_o, bus_error_o};

  // Clock and watchdog.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  // Reference instruction table.
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                   output int kind, output logic [4:0] alu);
    kind = KILL;
    alu  = 5'd0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin kind = KALU_R; alu = 5'd0;  end
        6'h22: begin kind = KALU_R; alu = 5'd1;  end
        6'h24: begin kind = KALU_R; alu = 5'd13; end
        6'h25: begin kind = KALU_R; alu = 5'd2;  end
        6'h27: begin kind = KALU_R; alu = 5'd12; end
        6'h00: begin kind = KALU_R; alu = 5'd5;  end
        6'h02: begin kind = KALU_R; alu = 5'd4;  end
        6'h08: begin kind = KPC;    alu = 5'd16; end
        default: ;
      endcase
    end else begin
      case (op)
        6'h08: begin kind = KALU_I; alu = 5'd0;  end
        6'h0C: begin kind = KALU_I; alu = 5'd7;  end
        6'h0D: begin kind = KALU_I; alu = 5'd3;  end
        6'h0F: begin kind = KALU_I; alu = 5'd6;  end
        6'h23: begin kind = KLW;    alu = 5'd0;  end
        6'h2B: begin kind = KSW;    alu = 5'd0;  end
        6'h04: begin kind = KPC;    alu = 5'd10; end
        6'h05: begin kind = KPC;    alu = 5'd11; end
        6'h02: begin kind = KPC;    alu = 5'd14; end
        6'h03: begin kind = KJAL;   alu = 5'd15; end
        default: ;
      endcase
    end
  endfunction

  function automatic void push(input obs_t o, input logic rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endfunction

  // Expected trace for one instruction. fw/mw are the numbers of not-ready
  // cycles before memory answers in FETCH/MEM. A value of LIMIT or more means
  // the memory never answers.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    obs_t o;
    int kind;
    logic [4:0] alu;
    classify(op, fn, kind, alu);
    for (int i = 0; i < fw; i++) begin
      o = '0; o.state = 3'd0; o.mem_read = 1'b1;
      if (i == LIMIT - 1) begin
        o.bus_error = 1'b1; push(o, 1'b0); return;
      end
      push(o, 1'b0);
    end
    o = '0; o.state = 3'd0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1);
    o = '0; o.state = 3'd1; o.illegal = (kind == KILL);
    push(o, 1'($urandom_range(0, 1)));
    if (kind == KILL) return;
    o = '0; o.state = 3'd2; o.alu_op = alu;
    o.alu_src_b = (kind == KALU_I || kind == KLW || kind == KSW);
    if (kind == KPC || kind == KJAL) begin
      o.pc_write = 1'b1; o.pc_src = 1'b1;
      if (kind == KJAL) begin o.reg_write = 1'b1; o.reg_dst = 2'd2; end
      push(o, 1'($urandom_range(0, 1)));
      return;
    end
    push(o, 1'($urandom_range(0, 1)));
    if (kind == KLW || kind == KSW) begin
      for (int i = 0; i < mw; i++) begin
        o = '0; o.state = 3'd3; o.i_or_d = 1'b1;
        o.mem_read = (kind == KLW); o.mem_write = (kind == KSW);
        if (i == LIMIT - 1) begin
          o.bus_error = 1'b1; push(o, 1'b0); return;
        end
        push(o, 1'b0);
      end
      o = '0; o.state = 3'd3; o.i_or_d = 1'b1;
      o.mem_read = (kind == KLW); o.mem_write = (kind == KSW);
      push(o, 1'b1);
      if (kind == KSW) return;
    end
    o = '0; o.state = 3'd4; o.reg_write = 1'b1;
    o.reg_dst = (kind == KALU_R) ? 2'd1 : 2'd0;
    o.mem_to_reg = (kind == KLW);
    push(o, 1'($urandom_range(0, 1)));
  endtask

  // Driver and scoreboard: replay the ready schedule and check each cycle.
  // Entered and left at posedge+1 of a FETCH cycle.
  task automatic run_plan(input string name);
    obs_t e;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready_i = rdy_q.pop_front();
      #2;
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL %s step %0d (cycle %0d): got %h (state %0d) expected %h (state %0d)",
                 name, n, cyc, got, got.state, e, e.state);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw);
    opcode_i = op;
    funct_i  = fn;
    plan_instr(op, fn, fw, mw);
    run_plan(name);
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1;
    mem_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (got !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    reset = 1'b0;
    #1;
    e = '0; e.mem_read = 1'b1;
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL reset_release_fetch: got %h expected %h", got, e);
    end
  endtask

  task automatic test_add();   do_instr("add", 6'h00, 6'h20, 0, 0); endtask
  task automatic test_lw_wait(); do_instr("lw_wait3", 6'h23, 6'h00, 0, 2); endtask
  task automatic test_beq();   do_instr("beq", 6'h04, 6'h00, 0, 0); endtask
  task automatic test_jal();   do_instr("jal", 6'h03, 6'h00, 0, 0); endtask
  task automatic test_illegal();
    do_instr("illegal_op3f", 6'h3F, 6'h00, 0, 0);
    do_instr("illegal_funct", 6'h00, 6'h3F, 0, 0);
  endtask

  task automatic test_timeouts();
    do_instr("fetch_timeout", 6'h00, 6'h20, LIMIT, 0);
    do_instr("fetch_ready_on_limit", 6'h00, 6'h22, LIMIT - 1, 0);
    do_instr("mem_ready_on_limit", 6'h23, 6'h00, 1, LIMIT - 1);
    do_instr("mem_timeout_sw", 6'h2B, 6'h00, 0, LIMIT);
  endtask

  task automatic test_reset_in_mem();
    obs_t e;
    obs_t m;
    opcode_i = 6'h23;
    funct_i  = 6'h00;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (state_o !== 3'd3 || mem_read_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_mem_reach: state %0d mem_read %b expected state 3 mem_read 1",
               state_o, mem_read_o);
    end
    reset = 1'b1;
    #1;
    m = got; m.state = 3'd0;
    tests++;
    if (m !== '0) begin
      failed++;
      $display("FAIL reset_mem_strobes: got %h expected 0", m);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    e = '0; e.mem_read = 1'b1;
    tests++;
    if (got !== e) begin
      failed++;
      $display("FAIL reset_mem_refetch: got %h expected %h", got, e);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[10] = '{6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns[8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
    logic [5:0] op, fn;
    int sel;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        op = 6'h00; fn = fns[$urandom_range(0, 7)];
      end else if (sel < 9) begin
        op = ops[$urandom_range(0, 9)]; fn = 6'($urandom);
      end else begin
        op = 6'($urandom); fn = 6'($urandom);
      end
      do_instr("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    do_instr("b2b_sw", 6'h2B, 6'h00, 0, 0);
    do_instr("b2b_lw", 6'h23, 6'h00, 0, 0);
    do_instr("b2b_jr", 6'h00, 6'h08, 0, 0);
    do_instr("b2b_lui", 6'h0F, 6'h00, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_back_to_back();
    test_timeouts();
    test_reset_in_mem();
    test_add();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
